// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN job dispatcher: default geometry,
// pixel/result word types and the dispatcher state encoding.
package cnn_pkg;

    localparam int CNN_DATA_W    = 32;
    localparam int CNN_IMG_WORDS = 64;

    typedef logic [CNN_DATA_W-1:0] pixel_t;
    typedef logic [CNN_DATA_W-1:0] result_t;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_ACC_RST = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESULT  = 3'd4
    } disp_state_e;

endpackage

// File: rtl/cnn_img_buffer.sv
// Image holding register file: IMG_WORDS x DATA_W words written one at a
// time by index, with the whole array exposed to the accelerator in parallel.
// Contents are data only and carry no reset.
module cnn_img_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_W    = CNN_DATA_W,
    parameter int IMG_WORDS = CNN_IMG_WORDS
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [$clog2(IMG_WORDS)-1:0] i_idx,
    input  logic [DATA_W-1:0]            i_data,
    output logic [DATA_W-1:0]            o_img [IMG_WORDS]
);

    logic [DATA_W-1:0] r_img [IMG_WORDS];

    // Store the incoming word at the write index when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_img[i_idx] <= i_data;
        end
    end

    assign o_img = r_img;

endmodule

// File: rtl/cnn_job_dispatcher.sv
// Host-side job initiator for one CNN accelerator core: gathers an image from
// the pixel stream, resets the accelerator, pulses enable, waits for done and
// hands the result out on the result stream.
// Optional build macro CNN_DISPATCH_TIMEOUT_EN adds a WAIT-state watchdog that
// returns a zero result flagged with res_err after TIMEOUT_CYCLES.
module cnn_job_dispatcher
    import cnn_pkg::*;
#(
    parameter int IMG_WORDS      = CNN_IMG_WORDS,
    parameter int DATA_W         = CNN_DATA_W,
    parameter int ACC_RST_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              acc_rst,
    output logic              acc_enable,
    output logic [DATA_W-1:0] acc_img [IMG_WORDS],
    input  logic              acc_done,
    input  logic [DATA_W-1:0] acc_value,
    output logic              busy,
    output logic [15:0]       jobs_done
);

    localparam int IDX_W = $clog2(IMG_WORDS);
    localparam int RC_W  = $clog2(ACC_RST_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IMG_WORDS - 1);
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(ACC_RST_CYCLES - 1);

    disp_state_e       r_state;
    disp_state_e       w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [DATA_W-1:0] r_res_data;
    logic [15:0]       r_jobs_done;
    logic              w_pix_take;
    logic              w_done_take;
    logic              w_res_take;

`ifdef CNN_DISPATCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_wait_cnt;
    logic            r_res_err;
    logic            w_timeout;
`else
    // TIMEOUT_CYCLES only sizes the optional watchdog; this empty guard keeps
    // the parameter referenced when the watchdog is compiled out.
    if (TIMEOUT_CYCLES < 1) begin : g_no_watchdog
    end
`endif

    cnn_img_buffer #(
        .DATA_W    (DATA_W),
        .IMG_WORDS (IMG_WORDS)
    ) u_img_buf (
        .clk    (clk),
        .i_we   (w_pix_take),
        .i_idx  (r_idx),
        .i_data (pix_data),
        .o_img  (acc_img)
    );

    // State register; reset abandons any job in flight and returns to LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, handshake qualifiers and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_pix_take  = 1'b0;
        w_done_take = 1'b0;
        w_res_take  = 1'b0;
`ifdef CNN_DISPATCH_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        pix_ready   = 1'b0;
        acc_rst     = 1'b0;
        acc_enable  = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_LOAD: begin
                pix_ready  = 1'b1;
                acc_rst    = 1'b1;
                busy       = 1'b0;
                w_pix_take = pix_valid;
                if (pix_valid && (r_idx == IDX_LAST)) begin
                    w_state_nxt = ST_ACC_RST;
                end
            end
            ST_ACC_RST: begin
                acc_rst = 1'b1;
                if (r_rst_cnt == RST_LAST) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                acc_enable  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving in the expiry cycle still counts as good.
                if (acc_done) begin
                    w_done_take = 1'b1;
                    w_state_nxt = ST_RESULT;
                end
`ifdef CNN_DISPATCH_TIMEOUT_EN
                else if (r_wait_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESULT;
                end
`endif
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_res_take  = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // Pixel write index and accelerator-reset hold counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx     <= '0;
            r_rst_cnt <= '0;
        end else begin
            if (w_pix_take) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (r_state == ST_ACC_RST) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end else begin
                r_rst_cnt <= '0;
            end
        end
    end

    // Result capture and handed-off job counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_data  <= '0;
            r_jobs_done <= '0;
        end else begin
            if (w_done_take) begin
                r_res_data <= acc_value;
            end
`ifdef CNN_DISPATCH_TIMEOUT_EN
            else if (w_timeout) begin
                r_res_data <= '0;
            end
`endif
            if (w_res_take) begin
                r_jobs_done <= r_jobs_done + 16'd1;
            end
        end
    end

`ifdef CNN_DISPATCH_TIMEOUT_EN
    // Watchdog: counts WAIT cycles and flags a result produced by expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_res_err  <= 1'b0;
        end else begin
            if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_done_take) begin
                r_res_err <= 1'b0;
            end else if (w_timeout) begin
                r_res_err <= 1'b1;
            end
        end
    end

    assign res_err = r_res_err;
`else
    assign res_err = 1'b0;
`endif

    assign res_data  = r_res_data;
    assign jobs_done = r_jobs_done;

endmodule
